// File: rtl/pid_pkg.sv
// Shared widths, output limits and default gains for the line-follower PID controller.
package pid_pkg;
  localparam int ERR_W     = 3;
  localparam int OUT_W     = 11;
  localparam int I_W       = 16;
  localparam int SUM_W     = 32;
  localparam int OUT_MAX   = 1023;
  localparam int OUT_MIN   = -1024;
  localparam int KP_DEF    = 32;
  localparam int KI_DEF    = 1;
  localparam int KD_DEF    = 16;
  localparam int I_MAX_DEF = 256;
endpackage

// File: rtl/pid_error_map.sv
// Maps the 4-bit IR sensor pattern to a signed position error; patterns that
// are not a contiguous run of lit sensors return the held error with valid=0.
module pid_error_map
  import pid_pkg::*;
(
  input  logic [3:0]       sensors,
  input  logic [ERR_W-1:0] held,
  output logic [ERR_W-1:0] err,
  output logic             valid
);

  always_comb begin
    err   = held;
    valid = 1'b1;
    case (sensors)
      4'b0110, 4'b1111: err = 3'b000;
      4'b0010, 4'b0111: err = 3'b001;
      4'b0011:          err = 3'b010;
      4'b0001:          err = 3'b011;
      4'b0100, 4'b1110: err = 3'b111;
      4'b1100:          err = 3'b110;
      4'b1000:          err = 3'b101;
      default:          valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pid.sv
// PID steering controller: sampled error/integral registers feed a saturated
// P+I+D correction registered every clock.
module pid
  import pid_pkg::*;
#(
  parameter int KP         = KP_DEF,
  parameter int KI         = KI_DEF,
  parameter int KD         = KD_DEF,
  parameter int I_MAX      = I_MAX_DEF,
  parameter int SAMPLE_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kp_sw,
  input  logic             ki_sw,
  input  logic             kd_sw,
  input  logic [3:0]       sensors,
  output logic [OUT_W-1:0] pid_output
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic signed [SUM_W-1:0] KP_S = SUM_W'(KP);
  localparam logic signed [SUM_W-1:0] KI_S = SUM_W'(KI);
  localparam logic signed [SUM_W-1:0] KD_S = SUM_W'(KD);

  function automatic logic signed [I_W-1:0] clamp_i(input logic signed [SUM_W-1:0] v);
    if (v > I_MAX)       return I_W'(I_MAX);
    else if (v < -I_MAX) return I_W'(-I_MAX);
    else                 return I_W'(v);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
    if (v > OUT_MAX)      return OUT_W'(OUT_MAX);
    else if (v < OUT_MIN) return OUT_W'(OUT_MIN);
    else                  return OUT_W'(v);
  endfunction

  logic [CNT_W-1:0]        cnt_q;
  logic                    sample_stb;
  logic signed [ERR_W-1:0] e_q;
  logic signed [ERR_W-1:0] e_prev_q;
  logic signed [I_W-1:0]   i_q;
  logic [ERR_W-1:0]        map_err;
  logic                    map_vld;
  logic signed [SUM_W-1:0] e_ext, e_prev_ext, map_ext, i_ext;
  logic signed [SUM_W-1:0] p_term, i_term, d_term, sum;

  pid_error_map u_error_map (
    .sensors (sensors),
    .held    (e_q),
    .err     (map_err),
    .valid   (map_vld)
  );

  assign sample_stb = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cnt_q <= '0;
    else if (sample_stb) cnt_q <= '0;
    else                 cnt_q <= cnt_q + 1'b1;
  end

  // Stage 1: sampled error, previous error and clamped integral
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q      <= '0;
      e_prev_q <= '0;
      i_q      <= '0;
    end else if (sample_stb) begin
      e_prev_q <= e_q;
      if (map_vld) e_q <= map_err;
      // Integral accumulates the effective error, including a held one
      i_q <= ki_sw ? clamp_i(i_ext + map_ext) : '0;
    end
  end

  always_comb begin
    e_ext      = {{(SUM_W-ERR_W){e_q[ERR_W-1]}}, e_q};
    e_prev_ext = {{(SUM_W-ERR_W){e_prev_q[ERR_W-1]}}, e_prev_q};
    map_ext    = {{(SUM_W-ERR_W){map_err[ERR_W-1]}}, map_err};
    i_ext      = {{(SUM_W-I_W){i_q[I_W-1]}}, i_q};
    p_term     = kp_sw ? KP_S * e_ext : '0;
    i_term     = ki_sw ? KI_S * i_ext : '0;
    d_term     = kd_sw ? KD_S * (e_ext - e_prev_ext) : '0;
    sum        = p_term + i_term + d_term;
  end

  // Stage 2: saturated correction, switches sampled every clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pid_output <= '0;
    else      pid_output <= sat_out(sum);
  end

endmodule

// File: tb/tb_pid.sv
// Bench for pid: table vectors, hand-written corner sequences and randomized
// traffic against a centroid-based reference model for three configurations.
module tb_pid;

  logic        clk = 1'b0;
  logic        rst;
  logic        kp_sw, ki_sw, kd_sw;
  logic [3:0]  sensors;
  logic [10:0] out0, out1, out2;

  int checks = 0;
  int errors = 0;

  // Reference configurations: default, high gain, slow sampling with small clamp
  int pkp[3] = '{32, 255, 7};
  int pki[3] = '{1, 1, 3};
  int pkd[3] = '{16, 255, 5};
  int pim[3] = '{256, 256, 20};
  int pdv[3] = '{1, 1, 3};
  int me[3], mp[3], mi[3], mo[3], mc[3];

  typedef struct {
    logic [3:0] s;
    logic       kp, ki, kd;
    int         exp;
  } vec_t;
  vec_t tbl[20];

  always #5 clk = ~clk;

  pid #(.KP(32), .KI(1), .KD(16), .I_MAX(256), .SAMPLE_DIV(1)) dut (
    .clk(clk), .rst(rst), .kp_sw(kp_sw), .ki_sw(ki_sw), .kd_sw(kd_sw),
    .sensors(sensors), .pid_output(out0));
  pid #(.KP(255), .KI(1), .KD(255), .I_MAX(256), .SAMPLE_DIV(1)) dut_sat (
    .clk(clk), .rst(rst), .kp_sw(kp_sw), .ki_sw(ki_sw), .kd_sw(kd_sw),
    .sensors(sensors), .pid_output(out1));
  pid #(.KP(7), .KI(3), .KD(5), .I_MAX(20), .SAMPLE_DIV(3)) dut_div (
    .clk(clk), .rst(rst), .kp_sw(kp_sw), .ki_sw(ki_sw), .kd_sw(kd_sw),
    .sensors(sensors), .pid_output(out2));

  function automatic int lim(int v, int lo, int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Position = centroid of a single contiguous run of lit sensors (bit0 weight +3, bit3 -3)
  function automatic void centroid(input logic [3:0] s, output bit ok, output int e);
    int lo = -1, hi = -1, cnt = 0, sum = 0;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (lo < 0) lo = b;
        hi = b;
        cnt++;
        sum += 3 - 2 * b;
      end
    end
    ok = (cnt > 0) && (hi - lo + 1 == cnt);
    e  = ok ? sum / cnt : 0;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      me[n] = 0; mp[n] = 0; mi[n] = 0; mo[n] = 0; mc[n] = 0;
    end
  endtask

  task automatic model_edge();
    bit ok;
    int e, p, i, d;
    for (int n = 0; n < 3; n++) begin
      p = kp_sw ? pkp[n] * me[n] : 0;
      i = ki_sw ? pki[n] * mi[n] : 0;
      d = kd_sw ? pkd[n] * (me[n] - mp[n]) : 0;
      mo[n] = lim(p + i + d, -1024, 1023);
      if (mc[n] == pdv[n] - 1) begin
        centroid(sensors, ok, e);
        if (!ok) e = me[n];
        mp[n] = me[n];
        me[n] = e;
        mi[n] = ki_sw ? lim(mi[n] + e, -pim[n], pim[n]) : 0;
      end
      mc[n] = (mc[n] + 1) % pdv[n];
    end
  endtask

  task automatic tick();
    if (rst) model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic int outv(int n);
    logic [10:0] t;
    case (n)
      0:       t = out0;
      1:       t = out1;
      default: t = out2;
    endcase
    return {{21{t[10]}}, t};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 1) == 0) sensors = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) {kp_sw, ki_sw, kd_sw} = 3'($urandom_range(0, 7));
      tick();
      for (int n = 0; n < 3; n++) chk($sformatf("rand_c%0d_dut%0d", c, n), outv(n), mo[n]);
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0011, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{4'b0011, 1'b1, 1'b0, 1'b0, 64};
    tbl[2]  = '{4'b1000, 1'b1, 1'b0, 1'b0, 64};
    tbl[3]  = '{4'b1000, 1'b1, 1'b0, 1'b0, -96};
    tbl[4]  = '{4'b0001, 1'b1, 1'b0, 1'b0, -96};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 96};
    tbl[6]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 96};
    tbl[7]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 96};
    tbl[8]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 0};
    tbl[9]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 0};
    tbl[10] = '{4'b0011, 1'b0, 1'b0, 1'b1, 0};
    tbl[11] = '{4'b0011, 1'b0, 1'b0, 1'b1, 32};
    tbl[12] = '{4'b0011, 1'b0, 1'b0, 1'b1, 0};
    tbl[13] = '{4'b1100, 1'b0, 1'b0, 1'b1, 0};
    tbl[14] = '{4'b1100, 1'b0, 1'b0, 1'b1, -64};
    tbl[15] = '{4'b1100, 1'b0, 1'b0, 1'b1, 0};
    tbl[16] = '{4'b0001, 1'b0, 1'b1, 1'b0, 0};
    tbl[17] = '{4'b0001, 1'b0, 1'b1, 1'b0, 3};
    tbl[18] = '{4'b0001, 1'b0, 1'b1, 1'b0, 6};
    tbl[19] = '{4'b0001, 1'b0, 1'b1, 1'b0, 9};

    // Reset with active switches and a garbage pattern
    rst = 1'b0;
    sensors = 4'b1011;
    {kp_sw, ki_sw, kd_sw} = 3'b111;
    model_reset();
    #3;
    for (int n = 0; n < 3; n++) chk($sformatf("reset_async_dut%0d", n), outv(n), 0);
    @(posedge clk);
    #1;
    chk("reset_held", outv(0), 0);
    rst = 1'b1;
    sensors = 4'b0110;
    tick();
    chk("post_reset_1", outv(0), 0);
    tick();
    chk("post_reset_2", outv(0), 0);

    // P, hold, D and I vectors
    for (int r = 0; r < 20; r++) begin
      sensors = tbl[r].s;
      {kp_sw, ki_sw, kd_sw} = {tbl[r].kp, tbl[r].ki, tbl[r].kd};
      tick();
      chk($sformatf("vec%0d", r), outv(0), tbl[r].exp);
    end

    // Integral ramp up to the clamp
    for (int k = 4; k <= 90; k++) begin
      tick();
      chk($sformatf("i_ramp_k%0d", k), outv(0), (3 * k > 256) ? 256 : 3 * k);
    end
    ki_sw = 1'b0;
    tick();
    chk("i_disable_out", outv(0), 0);
    ki_sw = 1'b1;
    sensors = 4'b0110;
    tick();
    chk("i_cleared", outv(0), 0);
    sensors = 4'b0001;
    tick();
    chk("i_restart_0", outv(0), 0);
    tick();
    chk("i_restart_3", outv(0), 3);

    // Saturation on the high-gain instance
    {kp_sw, ki_sw, kd_sw} = 3'b111;
    sensors = 4'b1000;
    repeat (3) tick();
    sensors = 4'b0001;
    tick();
    tick();
    chk("sat_pos", outv(1), 1023);
    sensors = 4'b1000;
    tick();
    tick();
    chk("sat_neg", outv(1), -1024);

    random_phase(200);

    // Reset in the middle of operation, then resume from zero error
    {kp_sw, ki_sw, kd_sw} = 3'b100;
    sensors = 4'b0011;
    rst = 1'b0;
    model_reset();
    #1;
    for (int n = 0; n < 3; n++) chk($sformatf("midreset_dut%0d", n), outv(n), 0);
    #2;
    rst = 1'b1;
    tick();
    chk("resume_0", outv(0), 0);
    tick();
    chk("resume_64", outv(0), 64);

    random_phase(120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
